// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One buffered instruction, tagged with the address it was fetched from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

   // BOOT lasts exactly one cycle after reset and issues the reset address.
   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } fetch_state_e;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched instructions with a synchronous flush.
// The head entry is read straight from storage registers, so the outputs
// never depend combinationally on the incoming push data.
module fetch_buffer
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         flush_i,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;

   // Next pointer and occupancy values; a flush empties the buffer and drops any push.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the block infers a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_i) wr_ptr_d = ~wr_ptr_q;
         if (pop_i)  rd_ptr_d = ~rd_ptr_q;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage is deliberately not reset; count_q alone says which entries are meaningful.
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // The issue logic upstream must never let a word arrive while the buffer is full.
   overflow_a: assert property (@(posedge clk) disable iff (reset)
      (push_i && !flush_i) |-> (count_q != 2'd2 || pop_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word fetches to a one-cycle-latency
// instruction memory, buffers returning words in a two-entry FIFO and
// presents them to decode with a valid/ready handshake. A redirect flushes
// the buffer, drops any in-flight word and restarts fetch at the new target.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int              BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] imem_addr,
   output logic            imem_req,
   input  logic [XLEN-1:0] imem_inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_inst
);

   localparam logic [1:0] DEPTH_C = 2'(BUF_DEPTH);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] inflight_pc_q;
   logic            inflight_q, inflight_d;
   logic            issue;
   logic            pop;
   logic [1:0]      count;
   logic [1:0]      occupancy;
   fetch_entry_t    head;
   fetch_entry_t    push_entry;

   // Words already owed to the buffer once this cycle's pop is taken into account.
   // inflight + count never exceeds two and a pop implies count >= 1, so this cannot wrap.
   assign pop       = out_valid && out_ready;
   assign occupancy = {1'b0, inflight_q} + count - {1'b0, pop};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_BOOT;
      else       state_q <= state_d;
   end

   // Next state: BOOT is a single cycle, RUN is held until the next reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_BOOT;
      endcase
   end

   // Issue decision: BOOT always fetches the reset address; RUN fetches while the
   // buffer has room. Nothing issues during reset or in a redirect cycle.
   always_comb begin
      issue = 1'b0;
      if (!reset && !redirect_valid) begin
         case (state_q)
            ST_BOOT: issue = 1'b1;
            ST_RUN:  issue = (occupancy < DEPTH_C);
            default: issue = 1'b0;
         endcase
      end
   end

   // Next fetch address and in-flight flag; a redirect overrides sequential advance.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid)  fetch_pc_d = align_word(redirect_pc);
      else if (issue)      fetch_pc_d = fetch_pc_q + XLEN'(4);
      inflight_d = issue;
   end

   // Fetch address and in-flight flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
      end
   end

   // Address tag for the word returning next cycle; only read while inflight_q is set.
   always_ff @(posedge clk) begin
      if (issue) inflight_pc_q <= fetch_pc_q;
   end

   assign push_entry = '{pc: inflight_pc_q, inst: imem_inst};

   // A redirect flushes at the end of its cycle, which also drops the word arriving then.
   fetch_buffer u_buffer (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (redirect_valid),
      .push_i      (inflight_q),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count)
   );

   assign imem_addr = fetch_pc_q;
   assign imem_req  = issue;
   assign out_valid = !reset && (count != 2'd0);
   assign out_pc    = head.pc;
   assign out_inst  = head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup stream, back-pressure, redirects
// (including wrap-around and back-to-back) and reset while the buffer is full.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] INST_KEY = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_inst;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // Instruction memory model: reads every cycle, data one cycle after the address.
   always @(posedge clk) imem_inst <= imem_addr ^ INST_KEY;

   fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_req       (imem_req),
      .imem_inst      (imem_inst),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs just after the rising edge, then check the settled outputs.
   task automatic step(input string tag, input logic rst, input logic rdy,
                       input logic rv, input logic [31:0] rpc,
                       input logic exp_req, input logic [31:0] exp_addr,
                       input logic exp_v, input logic [31:0] exp_pc);
      @(posedge clk);
      #1;
      reset          = rst;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      #1;
      check({tag, ".req"},   {31'b0, imem_req},  {31'b0, exp_req});
      check({tag, ".addr"},  imem_addr,          exp_addr);
      check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, exp_v});
      if (exp_v) begin
         check({tag, ".pc"},   out_pc,   exp_pc);
         check({tag, ".inst"}, out_inst, exp_pc ^ INST_KEY);
      end
   endtask

   // Two reset cycles; the second one checks the reset state.
   task automatic do_reset(input string tag);
      @(posedge clk);
      #1;
      reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
      #1;
      check({tag, ".rst_valid"}, {31'b0, out_valid}, 32'd0);
      check({tag, ".rst_req"},   {31'b0, imem_req},  32'd0);
      @(posedge clk);
      #1;
      check({tag, ".rst_valid2"}, {31'b0, out_valid}, 32'd0);
      check({tag, ".rst_req2"},   {31'b0, imem_req},  32'd0);
      check({tag, ".rst_addr"},   imem_addr,          32'h0);
   endtask

   initial begin
      // Startup stream with decode always ready.
      do_reset("boot");
      step("boot.c0", 0, 1, 0, 0, 1, 32'h00, 0, 0);
      step("boot.c1", 0, 1, 0, 0, 1, 32'h04, 0, 0);
      step("boot.c2", 0, 1, 0, 0, 1, 32'h08, 1, 32'h00);
      step("boot.c3", 0, 1, 0, 0, 1, 32'h0C, 1, 32'h04);
      step("boot.c4", 0, 1, 0, 0, 1, 32'h10, 1, 32'h08);
      step("boot.c5", 0, 1, 0, 0, 1, 32'h14, 1, 32'h0C);

      // Back-pressure: decode stalls for 5 cycles after the first valid word.
      do_reset("stall");
      step("stall.c0", 0, 1, 0, 0, 1, 32'h00, 0, 0);
      step("stall.c1", 0, 1, 0, 0, 1, 32'h04, 0, 0);
      for (int c = 2; c <= 6; c++)
         step($sformatf("stall.c%0d", c), 0, 0, 0, 0, 0, 32'h08, 1, 32'h00);
      step("stall.c7",  0, 1, 0, 0, 1, 32'h08, 1, 32'h00);
      step("stall.c8",  0, 1, 0, 0, 1, 32'h0C, 1, 32'h04);
      step("stall.c9",  0, 1, 0, 0, 1, 32'h10, 1, 32'h08);
      step("stall.c10", 0, 1, 0, 0, 1, 32'h14, 1, 32'h0C);

      // Redirect to 0x13 in cycle 6 while the head (0x10 of the old stream) is accepted.
      do_reset("redir");
      for (int c = 0; c <= 5; c++)
         step($sformatf("redir.c%0d", c), 0, 1, 0, 0, 1, 32'(4 * c), (c >= 2), 32'(4 * (c - 2)));
      step("redir.c6",  0, 1, 1, 32'h13, 0, 32'h18, 1, 32'h10);
      step("redir.c7",  0, 1, 0, 0,      1, 32'h10, 0, 0);
      step("redir.c8",  0, 1, 0, 0,      1, 32'h14, 0, 0);
      step("redir.c9",  0, 1, 0, 0,      1, 32'h18, 1, 32'h10);
      step("redir.c10", 0, 1, 0, 0,      1, 32'h1C, 1, 32'h14);

      // Back-to-back redirects; the second one targets the top word and wraps to 0.
      do_reset("wrap");
      step("wrap.c0", 0, 1, 0, 0,            1, 32'h00,        0, 0);
      step("wrap.c1", 0, 1, 0, 0,            1, 32'h04,        0, 0);
      step("wrap.c2", 0, 1, 0, 0,            1, 32'h08,        1, 32'h00);
      step("wrap.c3", 0, 1, 1, 32'h100,      0, 32'h0C,        1, 32'h04);
      step("wrap.c4", 0, 1, 1, 32'hFFFF_FFFE, 0, 32'h100,      0, 0);
      step("wrap.c5", 0, 1, 0, 0,            1, 32'hFFFF_FFFC, 0, 0);
      step("wrap.c6", 0, 1, 0, 0,            1, 32'h00,        0, 0);
      step("wrap.c7", 0, 1, 0, 0,            1, 32'h04,        1, 32'hFFFF_FFFC);
      step("wrap.c8", 0, 1, 0, 0,            1, 32'h08,        1, 32'h00);

      // Reset for one cycle with the buffer full (and a redirect that must be ignored).
      do_reset("mrst");
      step("mrst.c0", 0, 1, 0, 0,      1, 32'h00, 0, 0);
      step("mrst.c1", 0, 1, 0, 0,      1, 32'h04, 0, 0);
      step("mrst.c2", 0, 0, 0, 0,      0, 32'h08, 1, 32'h00);
      step("mrst.c3", 0, 0, 0, 0,      0, 32'h08, 1, 32'h00);
      step("mrst.c4", 1, 0, 1, 32'h80, 0, 32'h08, 0, 0);
      step("mrst.c5", 0, 1, 0, 0,      1, 32'h00, 0, 0);
      step("mrst.c6", 0, 1, 0, 0,      1, 32'h04, 0, 0);
      step("mrst.c7", 0, 1, 0, 0,      1, 32'h08, 1, 32'h00);
      step("mrst.c8", 0, 1, 0, 0,      1, 32'h0C, 1, 32'h04);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
